// File: rtl/datapath.sv
// Single-bus CPU datapath slice: PC, IR, MAR, MDR, Y, 64-bit Z and R2/R4/R5 sharing one bus.
// All loads and bus drives come from external per-register strobes.
module datapath #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               Clock,
  input  logic               Clear,
  input  logic               PC_Out,
  input  logic               ZLO_Out,
  input  logic               MDR_Out,
  input  logic               R2_Out,
  input  logic               R4_Out,
  input  logic               PC_In,
  input  logic               IR_In,
  input  logic               MAR_In,
  input  logic               MDR_In,
  input  logic               Y_In,
  input  logic               Z_In,
  input  logic               R2_In,
  input  logic               R4_In,
  input  logic               R5_In,
  input  logic               IncPC,
  input  logic               CONTROL,
  input  logic               Read,
  input  logic [WIDTH-1:0]   MData_In,
  output logic [WIDTH-1:0]   BusMuxOut,
  output logic [WIDTH-1:0]   PC_Q,
  output logic [WIDTH-1:0]   IR_Q,
  output logic [WIDTH-1:0]   MAR_Q,
  output logic [WIDTH-1:0]   MDR_Q,
  output logic [WIDTH-1:0]   Y_Q,
  output logic [2*WIDTH-1:0] Z_Q,
  output logic [WIDTH-1:0]   R2_Q,
  output logic [WIDTH-1:0]   R4_Q,
  output logic [WIDTH-1:0]   R5_Q
);

  logic [WIDTH-1:0]   pc_q, ir_q, mar_q, mdr_q, y_q, r2_q, r4_q, r5_q;
  logic [WIDTH-1:0]   pc_d, ir_d, mar_d, mdr_d, y_d, r2_d, r4_d, r5_d;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic [WIDTH-1:0]   bus;
  logic [WIDTH-1:0]   alu_lo;

  // Fixed-priority bus mux; an idle bus reads as zero.
  always_comb begin
    bus = '0;
    if (PC_Out)       bus = pc_q;
    else if (ZLO_Out) bus = z_q[WIDTH-1:0];
    else if (MDR_Out) bus = mdr_q;
    else if (R2_Out)  bus = r2_q;
    else if (R4_Out)  bus = r4_q;
  end

  // Increment wins over ADD; carry out of the low word is discarded.
  always_comb begin
    alu_lo = bus;
    if (IncPC)        alu_lo = bus + WIDTH'(1);
    else if (CONTROL) alu_lo = y_q + bus;
  end

  always_comb begin
    pc_d  = PC_In  ? bus : pc_q;
    ir_d  = IR_In  ? bus : ir_q;
    mar_d = MAR_In ? bus : mar_q;
    mdr_d = mdr_q;
    if (MDR_In) mdr_d = Read ? MData_In : bus;
    y_d   = Y_In   ? bus : y_q;
    z_d   = Z_In   ? {{WIDTH{1'b0}}, alu_lo} : z_q;
    r2_d  = R2_In  ? bus : r2_q;
    r4_d  = R4_In  ? bus : r4_q;
    r5_d  = R5_In  ? bus : r5_q;
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
      r2_q  <= '0;
      r4_q  <= '0;
      r5_q  <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      z_q   <= z_d;
      r2_q  <= r2_d;
      r4_q  <= r4_d;
      r5_q  <= r5_d;
    end
  end

  assign BusMuxOut = bus;
  assign PC_Q      = pc_q;
  assign IR_Q      = ir_q;
  assign MAR_Q     = mar_q;
  assign MDR_Q     = mdr_q;
  assign Y_Q       = y_q;
  assign Z_Q       = z_q;
  assign R2_Q      = r2_q;
  assign R4_Q      = r4_q;
  assign R5_Q      = r5_q;

endmodule

// File: tb/tb_datapath.sv
// Directed vector bench for the datapath slice: fetch, add, priority, wrap, hold and reset.
module tb_datapath;

  localparam logic [16:0] PCO  = 17'd1 << 0;
  localparam logic [16:0] ZLO  = 17'd1 << 1;
  localparam logic [16:0] MDRO = 17'd1 << 2;
  localparam logic [16:0] R2O  = 17'd1 << 3;
  localparam logic [16:0] R4O  = 17'd1 << 4;
  localparam logic [16:0] PCI  = 17'd1 << 5;
  localparam logic [16:0] IRI  = 17'd1 << 6;
  localparam logic [16:0] MARI = 17'd1 << 7;
  localparam logic [16:0] MDRI = 17'd1 << 8;
  localparam logic [16:0] YI   = 17'd1 << 9;
  localparam logic [16:0] ZI   = 17'd1 << 10;
  localparam logic [16:0] R2I  = 17'd1 << 11;
  localparam logic [16:0] R4I  = 17'd1 << 12;
  localparam logic [16:0] R5I  = 17'd1 << 13;
  localparam logic [16:0] INC  = 17'd1 << 14;
  localparam logic [16:0] CTL  = 17'd1 << 15;
  localparam logic [16:0] RD   = 17'd1 << 16;
  localparam logic [31:0] F    = 32'hFFFF_FFFF;

  typedef struct {
    logic [16:0] ctrl;
    logic [31:0] mdata;
    logic [31:0] bus, pc, ir, mar, mdr, y, z, r2, r4, r5;
  } vec_t;

  logic        Clock, Clear;
  logic        PC_Out, ZLO_Out, MDR_Out, R2_Out, R4_Out;
  logic        PC_In, IR_In, MAR_In, MDR_In, Y_In, Z_In, R2_In, R4_In, R5_In;
  logic        IncPC, CONTROL, Read;
  logic [31:0] MData_In, BusMuxOut;
  logic [31:0] PC_Q, IR_Q, MAR_Q, MDR_Q, Y_Q, R2_Q, R4_Q, R5_Q;
  logic [63:0] Z_Q;

  int   n_vec  = 0;
  int   n_miss = 0;
  vec_t vecs[29];
  vec_t zero_v, hold_v, v;
  logic [16:0] hold_ctrl[4];

  datapath #(.WIDTH(32)) dut (
    .Clock(Clock), .Clear(Clear),
    .PC_Out(PC_Out), .ZLO_Out(ZLO_Out), .MDR_Out(MDR_Out), .R2_Out(R2_Out), .R4_Out(R4_Out),
    .PC_In(PC_In), .IR_In(IR_In), .MAR_In(MAR_In), .MDR_In(MDR_In), .Y_In(Y_In),
    .Z_In(Z_In), .R2_In(R2_In), .R4_In(R4_In), .R5_In(R5_In),
    .IncPC(IncPC), .CONTROL(CONTROL), .Read(Read), .MData_In(MData_In),
    .BusMuxOut(BusMuxOut), .PC_Q(PC_Q), .IR_Q(IR_Q), .MAR_Q(MAR_Q), .MDR_Q(MDR_Q),
    .Y_Q(Y_Q), .Z_Q(Z_Q), .R2_Q(R2_Q), .R4_Q(R4_Q), .R5_Q(R5_Q)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic vec_t mk(input logic [16:0] c, input logic [31:0] md, input logic [31:0] b,
                              input logic [31:0] pc, input logic [31:0] ir,
                              input logic [31:0] mar, input logic [31:0] mdr,
                              input logic [31:0] y, input logic [31:0] z,
                              input logic [31:0] r2, input logic [31:0] r4,
                              input logic [31:0] r5);
    vec_t r;
    r.ctrl = c;  r.mdata = md; r.bus = b;
    r.pc = pc;   r.ir = ir;    r.mar = mar; r.mdr = mdr; r.y = y; r.z = z;
    r.r2 = r2;   r.r4 = r4;    r.r5 = r5;
    return r;
  endfunction

  task automatic drive(input logic [16:0] c, input logic [31:0] md);
    PC_Out = c[0];  ZLO_Out = c[1]; MDR_Out = c[2]; R2_Out = c[3]; R4_Out = c[4];
    PC_In = c[5];   IR_In = c[6];   MAR_In = c[7];  MDR_In = c[8]; Y_In = c[9];
    Z_In = c[10];   R2_In = c[11];  R4_In = c[12];  R5_In = c[13];
    IncPC = c[14];  CONTROL = c[15]; Read = c[16];
    MData_In = md;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input vec_t e);
    n_vec++;
    chk({tag, " PC_Q"},  {32'h0, PC_Q},  {32'h0, e.pc});
    chk({tag, " IR_Q"},  {32'h0, IR_Q},  {32'h0, e.ir});
    chk({tag, " MAR_Q"}, {32'h0, MAR_Q}, {32'h0, e.mar});
    chk({tag, " MDR_Q"}, {32'h0, MDR_Q}, {32'h0, e.mdr});
    chk({tag, " Y_Q"},   {32'h0, Y_Q},   {32'h0, e.y});
    chk({tag, " Z_Q"},   Z_Q,            {32'h0, e.z});
    chk({tag, " R2_Q"},  {32'h0, R2_Q},  {32'h0, e.r2});
    chk({tag, " R4_Q"},  {32'h0, R4_Q},  {32'h0, e.r4});
    chk({tag, " R5_Q"},  {32'h0, R5_Q},  {32'h0, e.r5});
  endtask

  // Drive one control step, check the bus before the edge and every register after it.
  task automatic apply(input string tag, input vec_t e);
    drive(e.ctrl, e.mdata);
    #1;
    n_vec++;
    chk({tag, " bus"}, {32'h0, BusMuxOut}, {32'h0, e.bus});
    @(posedge Clock);
    #1;
    chk_regs(tag, e);
  endtask

  initial begin
    //               ctrl                  mdata  bus    pc ir   mar  mdr  y  z    r2 r4 r5
    vecs[0]  = mk(RD | MDRI,               32'h22, 0,    0, 0,   0,   'h22, 0, 0,  0,    0,    0);
    vecs[1]  = mk(MDRO | R2I,              0, 'h22,      0, 0,   0,   'h22, 0, 0,  'h22, 0,    0);
    vecs[2]  = mk(RD | MDRI,               32'h24, 0,    0, 0,   0,   'h24, 0, 0,  'h22, 0,    0);
    vecs[3]  = mk(MDRO | R4I,              0, 'h24,      0, 0,   0,   'h24, 0, 0,  'h22, 'h24, 0);
    vecs[4]  = mk(RD | MDRI,               32'h26, 0,    0, 0,   0,   'h26, 0, 0,  'h22, 'h24, 0);
    vecs[5]  = mk(MDRO | R5I,              0, 'h26,      0, 0,   0,   'h26, 0, 0,  'h22, 'h24, 'h26);
    vecs[6]  = mk(PCO | MARI | INC | ZI,   0, 0,         0, 0,   0,   'h26, 0, 1,  'h22, 'h24, 'h26);
    vecs[7]  = mk(ZLO | PCI | RD | MDRI,   0, 1,         1, 0,   0,   0,    0, 1,  'h22, 'h24, 'h26);
    vecs[8]  = mk(MDRO | IRI,              0, 0,         1, 0,   0,   0,    0, 1,  'h22, 'h24, 'h26);
    vecs[9]  = mk(R2O | YI,                0, 'h22,      1, 0,   0,   0, 'h22, 1,  'h22, 'h24, 'h26);
    vecs[10] = mk(R4O | CTL | ZI,          0, 'h24,      1, 0,   0,   0, 'h22, 'h46, 'h22, 'h24, 'h26);
    vecs[11] = mk(ZLO | R5I,               0, 'h46,      1, 0,   0,   0, 'h22, 'h46, 'h22, 'h24, 'h46);
    vecs[12] = mk(PCO | R2O | R4O | YI,    0, 1,         1, 0,   0,   0, 1, 'h46, 'h22, 'h24, 'h46);
    vecs[13] = mk(ZI,                      0, 0,         1, 0,   0,   0, 1, 0,  'h22, 'h24, 'h46);
    vecs[14] = mk(R2O | R2I,               0, 'h22,      1, 0,   0,   0, 1, 0,  'h22, 'h24, 'h46);
    vecs[15] = mk(RD | MDRI,               F, 0,         1, 0,   0,   F, 1, 0,  'h22, 'h24, 'h46);
    vecs[16] = mk(MDRO | YI,               0, F,         1, 0,   0,   F, F, 0,  'h22, 'h24, 'h46);
    vecs[17] = mk(PCO | INC | ZI,          0, 1,         1, 0,   0,   F, F, 2,  'h22, 'h24, 'h46);
    vecs[18] = mk(PCO | CTL | ZI,          0, 1,         1, 0,   0,   F, F, 0,  'h22, 'h24, 'h46);
    vecs[19] = mk(MDRO | INC | CTL | ZI,   0, F,         1, 0,   0,   F, F, 0,  'h22, 'h24, 'h46);
    vecs[20] = mk(MDRO | ZI,               0, F,         1, 0,   0,   F, F, F,  'h22, 'h24, 'h46);
    vecs[21] = mk(R2O | ZI,                0, 'h22,      1, 0,   0,   F, F, 'h22, 'h22, 'h24, 'h46);
    vecs[22] = mk(ZLO | MDRO | R4I,        0, 'h22,      1, 0,   0,   F, F, 'h22, 'h22, 'h22, 'h46);
    vecs[23] = mk(MDRO | R2O | R5I,        0, F,         1, 0,   0,   F, F, 'h22, 'h22, 'h22, F);
    vecs[24] = mk(PCO | R4I,               0, 1,         1, 0,   0,   F, F, 'h22, 'h22, 1,    F);
    vecs[25] = mk(R2O | R4O | R5I,         0, 'h22,      1, 0,   0,   F, F, 'h22, 'h22, 1,    'h22);
    vecs[26] = mk(R2O | MDRI,              32'h99, 'h22, 1, 0,   0,   'h22, F, 'h22, 'h22, 1, 'h22);
    vecs[27] = mk(PCO | PCI | INC | ZI,    0, 1,         1, 0,   0,   'h22, F, 2,  'h22, 1,    'h22);
    vecs[28] = mk(R2O | MARI | IRI,        0, 'h22,      1, 'h22, 'h22, 'h22, F, 2, 'h22, 1,   'h22);

    zero_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    hold_ctrl[0] = PCO | INC;
    hold_ctrl[1] = R2O | CTL;
    hold_ctrl[2] = ZLO | RD;
    hold_ctrl[3] = MDRO | R4O;

    Clear = 1'b1;
    drive('0, '0);
    #3;
    chk_regs("reset", zero_v);
    n_vec++;
    chk("reset bus", {32'h0, BusMuxOut}, 64'h0);
    #4;
    Clear = 1'b0;

    for (int i = 0; i < 29; i++) apply($sformatf("v%0d", i), vecs[i]);

    // No load enables while the bus and memory data keep changing.
    hold_v = vecs[28];
    for (int i = 0; i < 4; i++) begin
      drive(hold_ctrl[i], $urandom);
      @(posedge Clock);
      #1;
      chk_regs($sformatf("hold%0d", i), hold_v);
    end

    // Clear between edges, held across an edge with loads asserted, then released.
    drive(PCO, 32'h0);
    #2;
    Clear = 1'b1;
    #1;
    chk_regs("midclr", zero_v);
    n_vec++;
    chk("midclr bus", {32'h0, BusMuxOut}, 64'h0);
    drive(RD | MDRI | PCI | R2I | YI, 32'h55);
    @(posedge Clock);
    #1;
    chk_regs("clr_over_load", zero_v);
    #2;
    Clear = 1'b0;
    @(posedge Clock);
    #1;
    v = mk(0, 0, 0, 0, 0, 0, 'h55, 0, 0, 0, 0, 0);
    chk_regs("resume", v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
